// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the memory-stage load/store unit: pipeline register structs,
// LSU FSM encoding and funct3 access-type constants.
package mem_stage_lsu_pkg;

    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT} LSU_FSM;

    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_H  = 3'b001;
    localparam logic [2:0] MT_W  = 3'b010;
    localparam logic [2:0] MT_BU = 3'b100;
    localparam logic [2:0] MT_HU = 3'b101;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ALUOutput;
        logic [31:0] rd2;
        logic [4:0]  rd;
        logic        RegWrite;
        logic        MemRead;
        logic        MemWrite;
        logic [3:0]  mem_type;
    } MEM_STATE;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] final_out;
        logic [4:0]  rd;
        logic        RegWrite;
    } WBACK_STATE;

    function automatic logic is_misaligned(input logic [2:0] mt, input logic [1:0] off);
        return ((mt == MT_H || mt == MT_HU) && off[0]) || (mt == MT_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane steering: store byte enables / replicated write data,
// and load lane selection with sign or zero extension.
module lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  mem_type,
    input  logic [1:0]  off,
    input  logic [31:0] rd2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_val
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        zero_ext;

    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        zero_ext = (mem_type == MT_BU) || (mem_type == MT_HU);
        be       = 4'hF;
        wdata    = rd2;
        load_val = rdata;
        case (mem_type)
            MT_B, MT_BU: begin
                be       = 4'b0001 << off;
                wdata    = {4{rd2[7:0]}};
                load_val = zero_ext ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            MT_H, MT_HU: begin
                be       = 4'b0011 << {off[1], 1'b0};
                wdata    = {2{rd2[15:0]}};
                load_val = zero_ext ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                be       = 4'hF;
                wdata    = rd2;
                load_val = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: req/gnt/rvalid data port, upstream stall, write-back register.
// Optional MISALIGN_TRAP_EN suppresses misaligned H/W accesses and pulses misalign_o.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter logic [31:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  MEM_STATE          mem_state,
    output logic              stall_o,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output WBACK_STATE        wb_state
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);

    LSU_FSM     state_q, state_d;
    logic       wb_valid_q, wb_valid_d;
    WBACK_STATE wb_state_q, wb_state_d;
    logic       misalign_d;

    logic        is_access, is_store, drive_bus, complete, misaligned;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load;
    logic        unused_mem_type_msb;

    assign unused_mem_type_msb = mem_state.mem_type[3];

    lsu_align u_align (
        .mem_type (mem_state.mem_type[2:0]),
        .off      (mem_state.ALUOutput[1:0]),
        .rd2      (mem_state.rd2),
        .rdata    (dmem_rdata),
        .be       (al_be),
        .wdata    (al_wdata),
        .load_val (al_load)
    );

`ifdef MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(mem_state.mem_type[2:0], mem_state.ALUOutput[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        is_access  = mem_valid && (mem_state.MemRead || mem_state.MemWrite);
        is_store   = mem_state.MemWrite && !mem_state.MemRead;
        state_d    = state_q;
        wb_valid_d = 1'b0;
        wb_state_d = wb_state_q;
        misalign_d = 1'b0;
        stall_o    = 1'b0;
        dmem_req   = 1'b0;
        drive_bus  = 1'b0;
        complete   = 1'b0;
        // Everything is gated by rst so the combinational port reads reset values too.
        if (!rst) begin
            case (state_q)
                LSU_IDLE: begin
                    if (mem_valid && !is_access) begin
                        wb_valid_d = 1'b1;
                        wb_state_d = '{pc: mem_state.pc, final_out: mem_state.ALUOutput,
                                       rd: mem_state.rd, RegWrite: mem_state.RegWrite};
                    end else if (is_access && misaligned) begin
                        wb_valid_d = 1'b1;
                        misalign_d = 1'b1;
                        wb_state_d = '{pc: mem_state.pc, final_out: mem_state.ALUOutput,
                                       rd: mem_state.rd, RegWrite: 1'b0};
                    end else if (is_access) begin
                        dmem_req  = 1'b1;
                        drive_bus = 1'b1;
                        if (dmem_gnt && is_store) begin
                            complete = 1'b1;
                        end else begin
                            stall_o = 1'b1;
                            state_d = dmem_gnt ? LSU_WAIT : LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    dmem_req  = 1'b1;
                    drive_bus = 1'b1;
                    if (dmem_gnt && is_store) begin
                        complete = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        if (dmem_gnt) state_d = LSU_WAIT;
                    end
                end
                LSU_WAIT: begin
                    if (dmem_rvalid) complete = 1'b1;
                    else             stall_o  = 1'b1;
                end
                default: state_d = LSU_IDLE;
            endcase
            if (complete) begin
                state_d    = LSU_IDLE;
                wb_valid_d = 1'b1;
                wb_state_d = '{pc: mem_state.pc,
                               final_out: is_store ? mem_state.ALUOutput : al_load,
                               rd: mem_state.rd,
                               RegWrite: is_store ? 1'b0 : mem_state.RegWrite};
            end
        end
        dmem_we    = drive_bus && is_store;
        dmem_addr  = drive_bus ? {mem_state.ALUOutput[ADDR_W-1:2], 2'b00} : '0;
        dmem_be    = drive_bus ? al_be : '0;
        dmem_wdata = drive_bus ? al_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LSU_IDLE;
            wb_valid_q <= 1'b0;
            wb_state_q <= '{pc: RST_PC, default: '0};
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_state_q <= wb_state_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;
    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end
    assign misalign_o = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_d;
`endif

    assign wb_valid = wb_valid_q;
    assign wb_state = wb_state_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus randomized ALU/load/store
// traffic against a transaction-level model. Honours MISALIGN_TRAP_EN when defined.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    localparam logic [31:0] TB_RST_PC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst, mem_valid, stall_o, dmem_req, dmem_we, dmem_gnt, dmem_rvalid, wb_valid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    MEM_STATE    ms;
    WBACK_STATE  ws;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(32), .RST_PC(TB_RST_PC)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_state(ms), .stall_o(stall_o),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_state(ws)
`ifdef MISALIGN_TRAP_EN
        , .misalign_o(misalign_o)
`endif
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte lanes from arithmetic shifts/multiplies on the whole word.
    function automatic logic [31:0] ref_load(input logic [2:0] mt, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] w;
        case (mt)
            MT_B, MT_BU: begin
                w = (rd >> (8 * a[1:0])) & 32'hFF;
                if (mt == MT_B && w[7]) w = w | 32'hFFFF_FF00;
            end
            MT_H, MT_HU: begin
                w = (rd >> (16 * a[1])) & 32'hFFFF;
                if (mt == MT_H && w[15]) w = w | 32'hFFFF_0000;
            end
            default: w = rd;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] mt, input logic [31:0] a);
        if (mt == MT_B || mt == MT_BU) return 4'(1 << (a % 4));
        if (mt == MT_H || mt == MT_HU) return 4'(3 << (a & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] mt, input logic [31:0] d);
        if (mt == MT_B) return (d & 32'hFF) * 32'h0101_0101;
        if (mt == MT_H) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic ref_trap(input logic [2:0] mt, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return ((mt == MT_H || mt == MT_HU) && (a % 2 != 0)) || (mt == MT_W && (a % 4 != 0));
`else
        return (mt == 3'b111) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic alu_op(input logic [31:0] res, input logic [4:0] rdi, input logic rw);
        logic [31:0] pcv;
        pcv = $urandom;
        mem_valid = 1'b1;
        ms = '{pc: pcv, ALUOutput: res, rd2: $urandom, rd: rdi, RegWrite: rw,
               MemRead: 1'b0, MemWrite: 1'b0, mem_type: 4'($urandom)};
        #1;
        chk("alu_req", dmem_req, 1'b0);
        chk("alu_stall", stall_o, 1'b0);
        tick();
        chk("alu_wbv", wb_valid, 1'b1);
        chk("alu_wbs", ws, {pcv, res, rdi, rw});
    endtask

    // One memory access: gnt arrives g cycles after the request, rvalid r>=1 cycles after gnt.
    task automatic mem_op(input logic ld, input logic st, input logic [2:0] mt, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rdv, input int unsigned g,
                          input int unsigned r, input logic [4:0] rdi, input logic rw);
        logic [31:0] pcv, fo;
        int unsigned done;
        pcv = $urandom;
        mem_valid = 1'b1;
        ms = '{pc: pcv, ALUOutput: a, rd2: d, rd: rdi, RegWrite: rw,
               MemRead: ld, MemWrite: st, mem_type: {1'($urandom), mt}};
        if (ref_trap(mt, a)) begin
            dmem_gnt = 1'b1;
            #1;
            chk("trap_req", dmem_req, 1'b0);
            chk("trap_stall", stall_o, 1'b0);
            tick();
            dmem_gnt = 1'b0;
            chk("trap_wbv", wb_valid, 1'b1);
            chk("trap_wbs", ws, {pcv, a, rdi, 1'b0});
`ifdef MISALIGN_TRAP_EN
            chk("trap_pulse", misalign_o, 1'b1);
            mem_valid = 1'b0;
            tick();
            chk("trap_pulse_end", misalign_o, 1'b0);
`endif
            return;
        end
        done = ld ? g + r : g;
        for (int c = 0; c <= int'(done); c++) begin
            dmem_gnt    = (c == int'(g));
            dmem_rvalid = ld && (c == int'(done));
            dmem_rdata  = dmem_rvalid ? rdv : $urandom;
            #1;
            chk("req", dmem_req, c <= int'(g));
            chk("stall", stall_o, c < int'(done));
            if (c <= int'(g)) begin
                chk("addr", dmem_addr, a & 32'hFFFF_FFFC);
                chk("be", dmem_be, ref_be(mt, a));
                chk("we", dmem_we, !ld);
                if (!ld) chk("wdata", dmem_wdata, ref_wdata(mt, d));
            end
            if (c > 0) chk("bubble", wb_valid, 1'b0);
            tick();
        end
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        fo = ld ? ref_load(mt, a, rdv) : a;
        chk("mem_wbv", wb_valid, 1'b1);
        chk("mem_wbs", ws, {pcv, fo, rdi, ld ? rw : 1'b0});
    endtask

    logic [2:0] ld_types [5] = '{MT_B, MT_H, MT_W, MT_BU, MT_HU};
    logic [2:0] st_types [3] = '{MT_B, MT_H, MT_W};

    initial begin
        rst = 1'b1; mem_valid = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        ms = '{pc: 32'h40, ALUOutput: 32'h104, rd2: 32'h55, rd: 5'd3, RegWrite: 1'b1,
               MemRead: 1'b1, MemWrite: 1'b0, mem_type: 4'h2};
        tick();
        tick();
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_we", dmem_we, 1'b0);
        chk("rst_be", dmem_be, 4'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_wbv", wb_valid, 1'b0);
        chk("rst_wbs", ws, {TB_RST_PC, 32'h0, 5'h0, 1'b0});
        rst = 1'b0;
        mem_valid = 1'b0;
        tick();
        chk("idle_wbv", wb_valid, 1'b0);

        alu_op(32'h1234, 5'd5, 1'b1);
        mem_op(1'b1, 1'b0, MT_B, 32'h103, 32'h0, 32'h80FF_FF7F, 1, 1, 5'd6, 1'b1);
        mem_op(1'b1, 1'b0, MT_HU, 32'h102, 32'h0, 32'h80FF_0000, 3, 2, 5'd7, 1'b1);
        mem_op(1'b0, 1'b1, MT_H, 32'h206, 32'hDEAD_BEEF, 32'h0, 0, 0, 5'd8, 1'b1);
        mem_op(1'b1, 1'b1, MT_W, 32'h300, 32'h1111_2222, 32'hCAFE_F00D, 0, 1, 5'd9, 1'b1);
        mem_op(1'b1, 1'b0, MT_W, 32'h101, 32'h0, 32'h1357_9BDF, 2, 1, 5'd10, 1'b1);

        // Reset while waiting for load data; the late rvalid must be ignored.
        mem_valid = 1'b1;
        ms = '{pc: 32'h500, ALUOutput: 32'h400, rd2: 32'h0, rd: 5'd11, RegWrite: 1'b1,
               MemRead: 1'b1, MemWrite: 1'b0, mem_type: {1'b0, MT_W}};
        dmem_gnt = 1'b1;
        #1;
        chk("pre_rst_req", dmem_req, 1'b1);
        tick();
        dmem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        chk("wait_rst_stall", stall_o, 1'b0);
        chk("wait_rst_req", dmem_req, 1'b0);
        tick();
        rst = 1'b0;
        mem_valid = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("post_rst_stall", stall_o, 1'b0);
        chk("post_rst_wbv", wb_valid, 1'b0);
        chk("post_rst_wbs", ws, {TB_RST_PC, 32'h0, 5'h0, 1'b0});
        tick();
        dmem_rvalid = 1'b0;
        chk("late_rvalid_wbv", wb_valid, 1'b0);
        chk("late_rvalid_wbs", ws, {TB_RST_PC, 32'h0, 5'h0, 1'b0});
        alu_op(32'hA5A5_0001, 5'd12, 1'b1);

        for (int i = 0; i < 60; i++) begin
            int unsigned kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a = {20'h0, 12'($urandom)};
            case (kind)
                0: alu_op($urandom, 5'($urandom), 1'($urandom));
                1: mem_op(1'b1, 1'($urandom), ld_types[$urandom_range(0, 4)], a, $urandom, $urandom,
                          $urandom_range(0, 3), $urandom_range(1, 3), 5'($urandom), 1'($urandom));
                2: mem_op(1'b0, 1'b1, st_types[$urandom_range(0, 2)], a, $urandom, $urandom,
                          $urandom_range(0, 3), 0, 5'($urandom), 1'($urandom));
                default: begin
                    mem_valid = 1'b0;
                    tick();
                    chk("idle_bubble", wb_valid, 1'b0);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
